// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: evaluates one of eight bitwise functions SLICE bits
// per cycle, LSB slice first, and reports the result with a zero flag and popcount.
module logic_unit_seq #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             data_A,
    input  logic [WIDTH-1:0]             data_B,
    output logic                         ready,
    output logic                         busy,
    output logic [WIDTH-1:0]             result,
    output logic                         result_rdy,
    output logic                         zero,
    output logic [$clog2(WIDTH+1)-1:0]   ones
);

    localparam int N  = WIDTH / SLICE;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam int OW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [2:0]        op_reg;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  shadow;
    logic [OW-1:0]     count;
    logic [SLICE-1:0]  slice_a;
    logic [SLICE-1:0]  slice_b;
    logic [SLICE-1:0]  slice_res;
    logic [WIDTH-1:0]  shadow_next;
    logic [OW-1:0]     count_next;
    logic              last;
    logic              accept;

    function automatic logic [SLICE-1:0] bit_fn(input logic [2:0] f,
                                                input logic [SLICE-1:0] a,
                                                input logic [SLICE-1:0] b);
        case (f)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a | b);
            3'b100:  return ~(a & b);
            3'b101:  return ~(a ^ b);
            3'b110:  return a & ~b;
            default: return a;
        endcase
    endfunction

    // Sized to OW so a full-width accumulation of all-ones cannot overflow.
    function automatic logic [OW-1:0] pop_fn(input logic [SLICE-1:0] s);
        logic [OW-1:0] c;
        c = '0;
        for (int i = 0; i < SLICE; i++) begin
            c = c + OW'(s[i]);
        end
        return c;
    endfunction

    assign ready  = (state == IDLE) || (state == DONE);
    assign busy   = (state == BUSY);
    assign accept = start && ready;
    assign last   = (k == KW'(N - 1));

    always_comb begin
        slice_a     = a_reg[k*SLICE +: SLICE];
        slice_b     = b_reg[k*SLICE +: SLICE];
        slice_res   = bit_fn(op_reg, slice_a, slice_b);
        shadow_next = shadow;
        shadow_next[k*SLICE +: SLICE] = slice_res;
        count_next  = count + pop_fn(slice_res);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = BUSY;
            BUSY:    if (last)  state_next = DONE;
            DONE:    state_next = start ? BUSY : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs only change on the final slice, so partial results never leak out.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            op_reg     <= '0;
            k          <= '0;
            shadow     <= '0;
            count      <= '0;
            result     <= '0;
            zero       <= 1'b1;
            ones       <= '0;
            result_rdy <= 1'b0;
        end else begin
            result_rdy <= 1'b0;
            if (accept) begin
                a_reg  <= data_A;
                b_reg  <= data_B;
                op_reg <= op;
                k      <= '0;
                shadow <= '0;
                count  <= '0;
            end else if (state == BUSY) begin
                shadow <= shadow_next;
                count  <= count_next;
                if (last) begin
                    result     <= shadow_next;
                    ones       <= count_next;
                    zero       <= (count_next == '0);
                    result_rdy <= 1'b1;
                end else begin
                    k <= k + KW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Directed bench for logic_unit_seq: main 32/8 instance plus three parameter-sweep instances.
module tb_logic_unit_seq;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] data_A;
    logic [31:0] data_B;
    logic        ready;
    logic        busy;
    logic [31:0] result;
    logic        result_rdy;
    logic        zero;
    logic [5:0]  ones;

    logic        start_s;
    logic [2:0]  op_s;
    logic [63:0] a_s;
    logic [63:0] b_s;
    logic        ready_s32, busy_s32, rdy_s32, zero_s32;
    logic [31:0] result_s32;
    logic [5:0]  ones_s32;
    logic        ready_s1, busy_s1, rdy_s1, zero_s1;
    logic [31:0] result_s1;
    logic [5:0]  ones_s1;
    logic        ready_s64, busy_s64, rdy_s64, zero_s64;
    logic [63:0] result_s64;
    logic [6:0]  ones_s64;

    int checks;
    int failures;

    logic_unit_seq #(.WIDTH(32), .SLICE(8)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .op(op),
        .data_A(data_A), .data_B(data_B), .ready(ready), .busy(busy),
        .result(result), .result_rdy(result_rdy), .zero(zero), .ones(ones)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(32)) u_s32 (
        .clock(clock), .reset_n(reset_n), .start(start_s), .op(op_s),
        .data_A(a_s[31:0]), .data_B(b_s[31:0]), .ready(ready_s32), .busy(busy_s32),
        .result(result_s32), .result_rdy(rdy_s32), .zero(zero_s32), .ones(ones_s32)
    );

    logic_unit_seq #(.WIDTH(32), .SLICE(1)) u_s1 (
        .clock(clock), .reset_n(reset_n), .start(start_s), .op(op_s),
        .data_A(a_s[31:0]), .data_B(b_s[31:0]), .ready(ready_s1), .busy(busy_s1),
        .result(result_s1), .result_rdy(rdy_s1), .zero(zero_s1), .ones(ones_s1)
    );

    logic_unit_seq #(.WIDTH(64), .SLICE(16)) u_s64 (
        .clock(clock), .reset_n(reset_n), .start(start_s), .op(op_s),
        .data_A(a_s), .data_B(b_s), .ready(ready_s64), .busy(busy_s64),
        .result(result_s64), .result_rdy(rdy_s64), .zero(zero_s64), .ones(ones_s64)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        op     = f;
        data_A = a;
        data_B = b;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        while (cyc < max_cyc) begin
            @(posedge clock);
            #1;
            cyc++;
            if (result_rdy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        checks++; if (zero !== 1'b1) begin failures++; $display("FAIL reset_zero got=%b exp=1", zero); end
        checks++; if (ones !== 6'd0) begin failures++; $display("FAIL reset_ones got=%0d exp=0", ones); end
        checks++; if (ready !== 1'b1 || busy !== 1'b0 || result_rdy !== 1'b0) begin
            failures++; $display("FAIL reset_ctrl got ready=%b busy=%b rdy=%b exp 1 0 0", ready, busy, result_rdy);
        end
        reset_n = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_or;
        launch(3'b001, 32'hF0F00000, 32'h00000F0F);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++; $display("FAIL or_accept got busy=%b ready=%b exp 1 0", busy, ready);
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            checks++; if (busy !== 1'b1 || result_rdy !== 1'b0 || result !== 32'h0) begin
                failures++; $display("FAIL or_busy%0d got busy=%b rdy=%b result=%h exp 1 0 00000000", i, busy, result_rdy, result);
            end
        end
        @(posedge clock);
        #1;
        checks++; if (result_rdy !== 1'b1 || busy !== 1'b0 || ready !== 1'b1) begin
            failures++; $display("FAIL or_done got rdy=%b busy=%b ready=%b exp 1 0 1", result_rdy, busy, ready);
        end
        checks++; if (result !== 32'hF0F00F0F) begin failures++; $display("FAIL or_result got=%h exp=%h", result, 32'hF0F00F0F); end
        checks++; if (ones !== 6'd16 || zero !== 1'b0) begin
            failures++; $display("FAIL or_flags got ones=%0d zero=%b exp 16 0", ones, zero);
        end
        @(posedge clock);
        #1;
        checks++; if (result_rdy !== 1'b0 || ready !== 1'b1 || busy !== 1'b0 || result !== 32'hF0F00F0F) begin
            failures++; $display("FAIL or_idle got rdy=%b ready=%b busy=%b result=%h exp 0 1 0 f0f00f0f", result_rdy, ready, busy, result);
        end
    endtask

    task automatic test_xor_nor;
        int  c;
        bit  ok;
        launch(3'b010, 32'hDEADBEEF, 32'hDEADBEEF);
        wait_done(10, c, ok);
        checks++; if (!ok || c != 4) begin failures++; $display("FAIL xor_latency got ok=%0d cycles=%0d exp 1 4", ok, c); end
        checks++; if (result !== 32'h0 || zero !== 1'b1 || ones !== 6'd0) begin
            failures++; $display("FAIL xor_result got result=%h zero=%b ones=%0d exp 00000000 1 0", result, zero, ones);
        end
        launch(3'b011, 32'h0, 32'h0);
        wait_done(10, c, ok);
        checks++; if (!ok || c != 4) begin failures++; $display("FAIL nor_latency got ok=%0d cycles=%0d exp 1 4", ok, c); end
        checks++; if (result !== 32'hFFFFFFFF || zero !== 1'b0 || ones !== 6'd32) begin
            failures++; $display("FAIL nor_result got result=%h zero=%b ones=%0d exp ffffffff 0 32", result, zero, ones);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_start_ignored;
        int          pulses;
        logic [31:0] got;
        logic [5:0]  got_ones;
        pulses   = 0;
        got      = 32'h0;
        got_ones = 6'd0;
        launch(3'b000, 32'hFFFF0000, 32'h0FF00FF0);
        data_A = 32'h0;
        @(posedge clock);
        #1;
        start  = 1'b1;
        op     = 3'b111;
        data_A = 32'h12345678;
        data_B = 32'h0;
        @(posedge clock);
        #1;
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (result_rdy) begin
                pulses++;
                got      = result;
                got_ones = ones;
            end
        end
        checks++; if (pulses != 1) begin failures++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
        checks++; if (got !== 32'h0FF00000 || got_ones !== 6'd8) begin
            failures++; $display("FAIL ignore_result got result=%h ones=%0d exp 0ff00000 8", got, got_ones);
        end
        checks++; if (busy !== 1'b0 || ready !== 1'b1) begin
            failures++; $display("FAIL ignore_idle got busy=%b ready=%b exp 0 1", busy, ready);
        end
    endtask

    task automatic test_back_to_back;
        int c;
        bit ok;
        launch(3'b001, 32'h00000003, 32'h0);
        wait_done(10, c, ok);
        checks++; if (!ok || c != 4 || result !== 32'h3) begin
            failures++; $display("FAIL b2b_first got ok=%0d cycles=%0d result=%h exp 1 4 00000003", ok, c, result);
        end
        launch(3'b110, 32'h000000FF, 32'h0000000F);
        checks++; if (busy !== 1'b1 || ready !== 1'b0) begin
            failures++; $display("FAIL b2b_accept got busy=%b ready=%b exp 1 0", busy, ready);
        end
        for (int i = 1; i <= 3; i++) begin
            @(posedge clock);
            #1;
            checks++; if (busy !== 1'b1 || result !== 32'h3 || ones !== 6'd2) begin
                failures++; $display("FAIL b2b_hold%0d got busy=%b result=%h ones=%0d exp 1 00000003 2", i, busy, result, ones);
            end
        end
        @(posedge clock);
        #1;
        checks++; if (result_rdy !== 1'b1 || result !== 32'h000000F0 || ones !== 6'd4 || zero !== 1'b0) begin
            failures++; $display("FAIL b2b_second got rdy=%b result=%h ones=%0d zero=%b exp 1 000000f0 4 0", result_rdy, result, ones, zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset_mid;
        int c;
        bit ok;
        int pulses;
        pulses = 0;
        launch(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(posedge clock);
        #1;
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++; if (result !== 32'h0 || zero !== 1'b1 || ones !== 6'd0) begin
            failures++; $display("FAIL rstmid_out got result=%h zero=%b ones=%0d exp 00000000 1 0", result, zero, ones);
        end
        checks++; if (ready !== 1'b1 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_ctrl got ready=%b busy=%b exp 1 0", ready, busy);
        end
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock);
            #1;
            if (result_rdy) pulses++;
        end
        checks++; if (pulses != 0 || result !== 32'h0) begin
            failures++; $display("FAIL rstmid_nopulse got pulses=%0d result=%h exp 0 00000000", pulses, result);
        end
        launch(3'b111, 32'h12345678, 32'hFFFFFFFF);
        wait_done(10, c, ok);
        checks++; if (!ok || c != 4) begin failures++; $display("FAIL rstmid_latency got ok=%0d cycles=%0d exp 1 4", ok, c); end
        checks++; if (result !== 32'h12345678 || ones !== 6'd13 || zero !== 1'b0) begin
            failures++; $display("FAIL rstmid_pass got result=%h ones=%0d zero=%b exp 12345678 13 0", result, ones, zero);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_sweep;
        int          cyc32, cyc1, cyc64;
        logic [31:0] r32, r1;
        logic [63:0] r64;
        logic        z32, z1, z64;
        cyc32 = 0; cyc1 = 0; cyc64 = 0;
        r32 = '1; r1 = '1; r64 = '1;
        z32 = 1'b0; z1 = 1'b0; z64 = 1'b0;
        op_s    = 3'b101;
        a_s     = {2{32'hAAAAAAAA}};
        b_s     = {2{32'h55555555}};
        start_s = 1'b1;
        @(posedge clock);
        #1;
        start_s = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock);
            #1;
            if (rdy_s32 && cyc32 == 0) begin cyc32 = c; r32 = result_s32; z32 = zero_s32; end
            if (rdy_s1 && cyc1 == 0)   begin cyc1 = c;  r1 = result_s1;   z1 = zero_s1;   end
            if (rdy_s64 && cyc64 == 0) begin cyc64 = c; r64 = result_s64; z64 = zero_s64; end
        end
        checks++; if (cyc32 != 1) begin failures++; $display("FAIL sweep32_latency got=%0d exp=1", cyc32); end
        checks++; if (r32 !== 32'h0 || z32 !== 1'b1) begin failures++; $display("FAIL sweep32_result got result=%h zero=%b exp 00000000 1", r32, z32); end
        checks++; if (cyc1 != 32) begin failures++; $display("FAIL sweep1_latency got=%0d exp=32", cyc1); end
        checks++; if (r1 !== 32'h0 || z1 !== 1'b1) begin failures++; $display("FAIL sweep1_result got result=%h zero=%b exp 00000000 1", r1, z1); end
        checks++; if (cyc64 != 4) begin failures++; $display("FAIL sweep64_latency got=%0d exp=4", cyc64); end
        checks++; if (r64 !== 64'h0 || z64 !== 1'b1) begin failures++; $display("FAIL sweep64_result got result=%h zero=%b exp 0 1", r64, z64); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 3'b000;
        data_A   = 32'h0;
        data_B   = 32'h0;
        start_s  = 1'b0;
        op_s     = 3'b000;
        a_s      = 64'h0;
        b_s      = 64'h0;
        test_reset;
        test_or;
        test_xor_nor;
        test_start_ignored;
        test_back_to_back;
        test_reset_mid;
        test_sweep;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
